// File: rtl/edge_event_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// edge_pkg
// Shared definitions for the edge event conditioner:
//   - 2-bit edge-select encodings (EDGE_OFF / EDGE_RISE / EDGE_FALL / EDGE_BOTH)
//   - edge_match(): decides whether a level transition is an event for a mode
// -----------------------------------------------------------------------------
package edge_pkg;

    localparam logic [1:0] EDGE_OFF  = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    // Returns 1 when the observed transition (rise/fall) is selected by mode.
    function automatic logic edge_match(input logic [1:0] mode,
                                        input logic       rise,
                                        input logic       fall);
        logic hit;
        case (mode)
            EDGE_OFF:  hit = 1'b0;
            EDGE_RISE: hit = rise;
            EDGE_FALL: hit = fall;
            EDGE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/edge_event_conditioner_channel.sv
// -----------------------------------------------------------------------------
// edge_channel
// One input channel: synchroniser -> polarity correction -> debounce ->
// edge pulse -> sticky pending flag.
// Configuration macro: EDGE_DEBOUNCE_EN (defined: debounce counter present;
// undefined: level follows the synchronised sample every cycle).
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   in_raw           raw asynchronous input
//   mode[1:0]        edge select (off / rising / falling / both)
//   clear            pending-flag clear (set has priority)
//   level            debounced, polarity-corrected level
//   pulse            one-cycle event pulse
//   pending          sticky event flag
//   pulse_next       next-state of pulse, used by the top for any_pulse
// -----------------------------------------------------------------------------
module edge_channel
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_raw,
    input  logic [1:0] mode,
    input  logic       clear,
    output logic       level,
    output logic       pulse,
    output logic       pending,
    output logic       pulse_next
);

    // Reset value of the synchroniser: the raw level of a released input.
    localparam logic INACTIVE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    // Parameter sanity checks, evaluated at elaboration.
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("edge_channel: SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("edge_channel: DEBOUNCE_CYCLES must be at least 1");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sample_s;
    logic                   level_q, level_d;
    logic                   pulse_q, pulse_d;
    logic                   pending_q, pending_d;
    logic                   rise_s, fall_s;

    // Synchroniser shift and polarity correction of its output.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], in_raw};
        sample_s = (ACTIVE_LOW != 0) ? ~sync_q[SYNC_STAGES-1] : sync_q[SYNC_STAGES-1];
    end

`ifdef EDGE_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sample_s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Debounce counter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // Without debouncing the level simply tracks the synchronised sample.
    always_comb begin
        level_d = sample_s;
    end
`endif

    // Event detection on the level next-state so pulse lands with the toggle;
    // pending is set from the registered pulse, so set beats clear.
    always_comb begin
        rise_s    = level_d & ~level_q;
        fall_s    = ~level_d & level_q;
        pulse_d   = edge_match(mode, rise_s, fall_s);
        pending_d = pulse_q | (pending_q & ~clear);
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= {SYNC_STAGES{INACTIVE}};
            level_q   <= 1'b0;
            pulse_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            level_q   <= level_d;
            pulse_q   <= pulse_d;
            pending_q <= pending_d;
        end
    end

    assign level      = level_q;
    assign pulse      = pulse_q;
    assign pending    = pending_q;
    assign pulse_next = pulse_d;

endmodule

// File: rtl/edge_event_conditioner.sv
// -----------------------------------------------------------------------------
// edge_event_conditioner
// Multi-channel input conditioner: per channel synchronise, polarity-correct,
// debounce, detect selectable edges and hold a sticky pending flag.
// Configuration macro: EDGE_DEBOUNCE_EN (see edge_channel).
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_raw[CHANNELS]      raw asynchronous inputs
//   mode[2*CHANNELS]      edge select, channel i at [2i+1:2i]
//   clear[CHANNELS]       pending-flag clears
//   level[CHANNELS]       debounced levels
//   pulse[CHANNELS]       one-cycle event pulses
//   pending[CHANNELS]     sticky event flags
//   any_pulse             OR of all pulses, coincident with them
// -----------------------------------------------------------------------------
module edge_event_conditioner
    import edge_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CHANNELS-1:0]   in_raw,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   clear,
    output logic [CHANNELS-1:0]   level,
    output logic [CHANNELS-1:0]   pulse,
    output logic [CHANNELS-1:0]   pending,
    output logic                  any_pulse
);

    logic [CHANNELS-1:0] pulse_next_s;
    logic                any_pulse_q, any_pulse_d;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        edge_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_channel (
            .clk        (clk),
            .reset      (reset),
            .in_raw     (in_raw[i]),
            .mode       (mode[2*i+1:2*i]),
            .clear      (clear[i]),
            .level      (level[i]),
            .pulse      (pulse[i]),
            .pending    (pending[i]),
            .pulse_next (pulse_next_s[i])
        );
    end

    // OR of the pulse next-states, so the registered result matches pulse.
    always_comb begin
        any_pulse_d = |pulse_next_s;
    end

    // any_pulse register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            any_pulse_q <= 1'b0;
        end else begin
            any_pulse_q <= any_pulse_d;
        end
    end

    assign any_pulse = any_pulse_q;

endmodule
